// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction-fetch / data-stage memory arbiter.
package mem_arbiter_pkg;
   // Who owns the read response coming back from memory next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MB   = 2'd2
   } rd_owner_e;

   localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and memory-command signals around the arbiter.
// slave = the arbiter's view, master = the requesters plus the memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8
);
   logic              if_arb__req;
   logic [ADDR_W-1:0] if_arb__addr;
   logic              arb_if__gnt;
   logic              arb_if__rvalid;
   logic [31:0]       arb_if__rdata;

   logic              mb_arb__req;
   logic              mb_arb__we;
   logic [3:0]        mb_arb__be;
   logic [ADDR_W-1:0] mb_arb__addr;
   logic [31:0]       mb_arb__wdata;
   logic              arb_mb__gnt;
   logic              arb_mb__rvalid;
   logic [31:0]       arb_mb__rdata;

   logic              pipe_flush;

   logic              mem__en;
   logic [3:0]        mem__we;
   logic [ADDR_W-1:0] mem__addr;
   logic [31:0]       mem__wdata;
   logic [31:0]       mem__rdata;

   modport slave (
      input  if_arb__req, if_arb__addr,
      output arb_if__gnt, arb_if__rvalid, arb_if__rdata,
      input  mb_arb__req, mb_arb__we, mb_arb__be, mb_arb__addr, mb_arb__wdata,
      output arb_mb__gnt, arb_mb__rvalid, arb_mb__rdata,
      input  pipe_flush,
      output mem__en, mem__we, mem__addr, mem__wdata,
      input  mem__rdata
   );

   modport master (
      output if_arb__req, if_arb__addr,
      input  arb_if__gnt, arb_if__rvalid, arb_if__rdata,
      output mb_arb__req, mb_arb__we, mb_arb__be, mb_arb__addr, mb_arb__wdata,
      input  arb_mb__gnt, arb_mb__rvalid, arb_mb__rdata,
      output pipe_flush,
      output mem__rdata,
      input  mem__en, mem__we, mem__addr, mem__wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data stage normally wins, fetch is forced through
// after STARVE_MAX contested losses. Read data returns one cycle after grant and
// is steered back by a registered owner tag; a fetch redirect kills fetch data.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   localparam int             SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);

   rd_owner_e         r_owner, w_owner_nxt;
   logic [SW-1:0]     r_starve, w_starve_nxt;
   logic              r_kill, w_kill_nxt;
   logic              w_gnt_if, w_gnt_mb, w_contested;
   logic [ADDR_W-1:0] w_addr;

   // Grant: mb wins contests unless fetch has been starved; reset masks all grants.
   always_comb begin
      w_contested = bus.if_arb__req & bus.mb_arb__req;
      w_gnt_if    = rst_n & bus.if_arb__req & (~bus.mb_arb__req | (r_starve == SMAX));
      w_gnt_mb    = rst_n & bus.mb_arb__req & ~w_gnt_if;
   end

   // Memory command follows whichever requester holds the grant.
   always_comb begin
      w_addr         = w_gnt_mb ? bus.mb_arb__addr : bus.if_arb__addr;
      bus.mem__en    = w_gnt_if | w_gnt_mb;
      bus.mem__addr  = w_addr;
      bus.mem__wdata = bus.mb_arb__wdata;
      bus.mem__we    = (w_gnt_mb & bus.mb_arb__we) ? bus.mb_arb__be : 4'b0000;
   end

   // Next-state: starvation counter, response owner and fetch-kill flag.
   always_comb begin
      w_starve_nxt = r_starve;
      w_owner_nxt  = OWN_NONE;
      w_kill_nxt   = 1'b0;
      if (w_gnt_if) begin
         w_starve_nxt = '0;
         w_owner_nxt  = OWN_IF;
         // A redirect in the grant cycle already makes this fetch stale.
         w_kill_nxt   = bus.pipe_flush;
      end else if (w_gnt_mb) begin
         if (w_contested && (r_starve != SMAX))
            w_starve_nxt = r_starve + SW'(1);
         if (!bus.mb_arb__we)
            w_owner_nxt = OWN_MB;
      end
   end

   // State registers; reset drops any read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner  <= OWN_NONE;
         r_starve <= '0;
         r_kill   <= 1'b0;
      end else begin
         r_owner  <= w_owner_nxt;
         r_starve <= w_starve_nxt;
         r_kill   <= w_kill_nxt;
      end
   end

   // Response steering: both ports see memory data, rvalid selects the owner.
   always_comb begin
      bus.arb_if__gnt    = w_gnt_if;
      bus.arb_mb__gnt    = w_gnt_mb;
      bus.arb_if__rvalid = (r_owner == OWN_IF) & ~r_kill & ~bus.pipe_flush;
      bus.arb_mb__rvalid = (r_owner == OWN_MB);
      bus.arb_if__rdata  = bus.mem__rdata;
      bus.arb_mb__rdata  = bus.mem__rdata;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model with a shadow memory.
module tb_mem_arbiter;
   logic clk;
   logic rst_n;

   mem_arbiter_if #(.ADDR_W(8)) bus();

   mem_arbiter #(.ADDR_W(8), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port memory outside the arbiter.
   logic [31:0] mem_arr [0:255];
   logic [31:0] r_rdata;
   assign bus.mem__rdata = r_rdata;

   always @(posedge clk) begin
      if (bus.mem__en) begin
         if (bus.mem__we == 4'b0000)
            r_rdata <= mem_arr[bus.mem__addr];
         else
            for (int b = 0; b < 4; b++)
               if (bus.mem__we[b]) mem_arr[bus.mem__addr][b*8 +: 8] <= bus.mem__wdata[b*8 +: 8];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   logic [31:0] ref_mem [0:255];
   int          m_starve;
   int          m_pend;       // 0 none, 1 fetch, 2 data stage
   logic [31:0] m_pend_data;
   bit          m_pend_kill;
   int          m_winner;

   // Model expectations for the current cycle.
   bit          e_gnt_if, e_gnt_mb, e_en, e_rv_if, e_rv_mb;
   logic [7:0]  e_addr;
   logic [3:0]  e_we;
   logic [31:0] e_rdata;

   task automatic model_reset();
      m_starve = 0; m_pend = 0; m_pend_kill = 0; m_pend_data = '0; m_winner = 0;
   endtask

   task automatic model_eval();
      if (bus.if_arb__req && (!bus.mb_arb__req || m_starve >= 4)) m_winner = 1;
      else if (bus.mb_arb__req) m_winner = 2;
      else m_winner = 0;
      e_gnt_if = (m_winner == 1);
      e_gnt_mb = (m_winner == 2);
      e_en     = (m_winner != 0);
      e_addr   = (m_winner == 2) ? bus.mb_arb__addr : bus.if_arb__addr;
      e_we     = (m_winner == 2 && bus.mb_arb__we) ? bus.mb_arb__be : 4'b0000;
      e_rv_if  = (m_pend == 1) && !m_pend_kill && !bus.pipe_flush;
      e_rv_mb  = (m_pend == 2);
      e_rdata  = m_pend_data;
   endtask

   task automatic model_commit();
      if (m_winner == 1) m_starve = 0;
      else if (m_winner == 2 && bus.if_arb__req) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
      m_pend = 0; m_pend_kill = 0;
      if (m_winner == 1) begin
         m_pend = 1; m_pend_data = ref_mem[bus.if_arb__addr]; m_pend_kill = bus.pipe_flush;
      end else if (m_winner == 2 && !bus.mb_arb__we) begin
         m_pend = 2; m_pend_data = ref_mem[bus.mb_arb__addr];
      end else if (m_winner == 2) begin
         for (int b = 0; b < 4; b++)
            if (bus.mb_arb__be[b]) ref_mem[bus.mb_arb__addr][b*8 +: 8] = bus.mb_arb__wdata[b*8 +: 8];
      end
   endtask

   task automatic set_idle();
      bus.if_arb__req = 0; bus.if_arb__addr = '0;
      bus.mb_arb__req = 0; bus.mb_arb__we = 0; bus.mb_arb__be = '0;
      bus.mb_arb__addr = '0; bus.mb_arb__wdata = '0; bus.pipe_flush = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      set_idle();
      bus.if_arb__req = 1; bus.mb_arb__req = 1;
      #3;
      n_tests++; if (bus.arb_if__gnt !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt got %b want 0", bus.arb_if__gnt); end
      n_tests++; if (bus.arb_mb__gnt !== 1'b0) begin n_fail++; $display("FAIL reset_mb_gnt got %b want 0", bus.arb_mb__gnt); end
      n_tests++; if (bus.mem__en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", bus.mem__en); end
      n_tests++; if ({bus.arb_if__rvalid, bus.arb_mb__rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {bus.arb_if__rvalid, bus.arb_mb__rvalid}); end
      @(negedge clk); set_idle();
      @(negedge clk); rst_n = 1;
      model_reset();
   endtask

   task automatic test_solo_fetch();
      mem_arr[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
      @(negedge clk); set_idle(); bus.if_arb__req = 1; bus.if_arb__addr = 8'h10;
      #1; model_eval();
      n_tests++; if ({bus.arb_if__gnt, bus.arb_mb__gnt} !== 2'b10) begin n_fail++; $display("FAIL solo_gnt got %b want 10", {bus.arb_if__gnt, bus.arb_mb__gnt}); end
      n_tests++; if (bus.mem__en !== 1'b1 || bus.mem__addr !== 8'h10 || bus.mem__we !== 4'b0) begin n_fail++; $display("FAIL solo_cmd got en=%b addr=%h we=%b want 1/10/0000", bus.mem__en, bus.mem__addr, bus.mem__we); end
      @(posedge clk); model_commit();
      @(negedge clk); set_idle();
      #1; model_eval();
      n_tests++; if (bus.arb_if__rvalid !== 1'b1 || bus.arb_if__rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL solo_resp got v=%b d=%h want 1/deadbeef", bus.arb_if__rvalid, bus.arb_if__rdata); end
      n_tests++; if (bus.arb_mb__rvalid !== 1'b0) begin n_fail++; $display("FAIL solo_mb_rvalid got %b want 0", bus.arb_mb__rvalid); end
      @(posedge clk); model_commit();
   endtask

   task automatic test_starvation();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); set_idle();
         bus.if_arb__req = 1; bus.if_arb__addr = 8'(k);
         bus.mb_arb__req = 1; bus.mb_arb__addr = 8'(k + 64);
         #1; model_eval();
         n_tests++;
         if ({bus.arb_if__gnt, bus.arb_mb__gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL starve_k%0d got %b want %b", k, {bus.arb_if__gnt, bus.arb_mb__gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
         end
         @(posedge clk); model_commit();
      end
      @(negedge clk); set_idle();
      @(posedge clk); model_eval(); model_commit();
   endtask

   task automatic test_write_read();
      mem_arr[8'h20] = 32'h0; ref_mem[8'h20] = 32'h0;
      @(negedge clk); set_idle();
      bus.mb_arb__req = 1; bus.mb_arb__we = 1; bus.mb_arb__be = 4'b0011;
      bus.mb_arb__addr = 8'h20; bus.mb_arb__wdata = 32'h1234ABCD;
      #1; model_eval();
      n_tests++; if (bus.arb_mb__gnt !== 1'b1 || bus.mem__we !== 4'b0011 || bus.mem__wdata !== 32'h1234ABCD || bus.mem__addr !== 8'h20) begin
         n_fail++; $display("FAIL wr_cmd got gnt=%b we=%b wd=%h a=%h want 1/0011/1234abcd/20", bus.arb_mb__gnt, bus.mem__we, bus.mem__wdata, bus.mem__addr);
      end
      @(posedge clk); model_commit();
      @(negedge clk); set_idle();
      bus.mb_arb__req = 1; bus.mb_arb__addr = 8'h20;
      #1; model_eval();
      n_tests++; if ({bus.arb_if__rvalid, bus.arb_mb__rvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_no_rvalid got %b want 00", {bus.arb_if__rvalid, bus.arb_mb__rvalid}); end
      n_tests++; if (bus.arb_mb__gnt !== 1'b1 || bus.mem__we !== 4'b0) begin n_fail++; $display("FAIL rd_cmd got gnt=%b we=%b want 1/0000", bus.arb_mb__gnt, bus.mem__we); end
      @(posedge clk); model_commit();
      @(negedge clk); set_idle();
      #1; model_eval();
      n_tests++; if (bus.arb_mb__rvalid !== 1'b1 || bus.arb_mb__rdata !== 32'h0000ABCD) begin n_fail++; $display("FAIL rd_resp got v=%b d=%h want 1/0000abcd", bus.arb_mb__rvalid, bus.arb_mb__rdata); end
      @(posedge clk); model_commit();
   endtask

   task automatic test_flush_kill();
      mem_arr[8'h30] = 32'hCAFEF00D; ref_mem[8'h30] = 32'hCAFEF00D;
      // flush in the response cycle, flush in the grant cycle, then no flush
      for (int v = 0; v < 3; v++) begin
         @(negedge clk); set_idle();
         bus.if_arb__req = 1; bus.if_arb__addr = 8'h30; bus.pipe_flush = (v == 1);
         #1; model_eval();
         n_tests++; if (bus.arb_if__gnt !== 1'b1) begin n_fail++; $display("FAIL flush_gnt_v%0d got %b want 1", v, bus.arb_if__gnt); end
         @(posedge clk); model_commit();
         @(negedge clk); set_idle(); bus.pipe_flush = (v == 0);
         #1; model_eval();
         n_tests++; if (bus.arb_if__rvalid !== ((v == 2) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL flush_rvalid_v%0d got %b want %b", v, bus.arb_if__rvalid, (v == 2)); end
         @(posedge clk); model_commit();
      end
   endtask

   task automatic test_alternating();
      for (int k = 0; k < 13; k++) begin
         @(negedge clk); set_idle();
         if (k < 12) begin
            if (k % 2 == 0) begin bus.if_arb__req = 1; bus.if_arb__addr = 8'($urandom_range(0, 255)); end
            else begin bus.mb_arb__req = 1; bus.mb_arb__addr = 8'($urandom_range(0, 255)); end
         end
         #1; model_eval();
         n_tests++;
         if ({bus.arb_if__gnt, bus.arb_mb__gnt} !== ((k == 12) ? 2'b00 : (k % 2 == 0) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL alt_gnt_k%0d got %b", k, {bus.arb_if__gnt, bus.arb_mb__gnt});
         end
         if (k > 0) begin
            n_tests++;
            if (bus.arb_if__rvalid !== (k % 2 == 1) || bus.arb_mb__rvalid !== (k % 2 == 0) || bus.arb_if__rdata !== e_rdata) begin
               n_fail++; $display("FAIL alt_resp_k%0d got if=%b mb=%b d=%h want d=%h", k, bus.arb_if__rvalid, bus.arb_mb__rvalid, bus.arb_if__rdata, e_rdata);
            end
         end
         @(posedge clk); model_commit();
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk); set_idle(); bus.if_arb__req = 1; bus.if_arb__addr = 8'h10;
      #1; model_eval();
      @(posedge clk); model_commit();
      #2; rst_n = 0;
      #1;
      n_tests++; if ({bus.arb_if__gnt, bus.arb_mb__gnt, bus.mem__en} !== 3'b000) begin n_fail++; $display("FAIL arst_gnt_en got %b want 000", {bus.arb_if__gnt, bus.arb_mb__gnt, bus.mem__en}); end
      n_tests++; if ({bus.arb_if__rvalid, bus.arb_mb__rvalid} !== 2'b00) begin n_fail++; $display("FAIL arst_rvalid got %b want 00", {bus.arb_if__rvalid, bus.arb_mb__rvalid}); end
      @(negedge clk); set_idle();
      @(negedge clk); rst_n = 1; model_reset();
      for (int k = 0; k < 2; k++) begin
         #1; model_eval();
         n_tests++; if ({bus.arb_if__rvalid, bus.arb_mb__rvalid} !== 2'b00) begin n_fail++; $display("FAIL arst_stale_k%0d got %b want 00", k, {bus.arb_if__rvalid, bus.arb_mb__rvalid}); end
         @(posedge clk); model_commit();
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         bus.if_arb__req   = ($urandom_range(0, 3) != 0);
         bus.if_arb__addr  = 8'($urandom_range(0, 15));
         bus.mb_arb__req   = ($urandom_range(0, 2) != 0);
         bus.mb_arb__we    = $urandom_range(0, 1);
         bus.mb_arb__be    = 4'($urandom_range(0, 15));
         bus.mb_arb__addr  = 8'($urandom_range(0, 15));
         bus.mb_arb__wdata = $urandom;
         bus.pipe_flush    = ($urandom_range(0, 5) == 0);
         #1; model_eval();
         n_tests++;
         if (bus.arb_if__gnt !== e_gnt_if || bus.arb_mb__gnt !== e_gnt_mb || bus.mem__en !== e_en) begin
            n_fail++; $display("FAIL rnd_gnt_k%0d got if=%b mb=%b en=%b want %b/%b/%b", k, bus.arb_if__gnt, bus.arb_mb__gnt, bus.mem__en, e_gnt_if, e_gnt_mb, e_en);
         end
         if (e_en) begin
            n_tests++;
            if (bus.mem__addr !== e_addr || bus.mem__we !== e_we) begin
               n_fail++; $display("FAIL rnd_cmd_k%0d got a=%h we=%b want a=%h we=%b", k, bus.mem__addr, bus.mem__we, e_addr, e_we);
            end
         end
         n_tests++;
         if (bus.arb_if__rvalid !== e_rv_if || bus.arb_mb__rvalid !== e_rv_mb) begin
            n_fail++; $display("FAIL rnd_rvalid_k%0d got if=%b mb=%b want %b/%b", k, bus.arb_if__rvalid, bus.arb_mb__rvalid, e_rv_if, e_rv_mb);
         end
         if (e_rv_if || e_rv_mb) begin
            n_tests++;
            if (bus.arb_if__rdata !== e_rdata || bus.arb_mb__rdata !== e_rdata) begin
               n_fail++; $display("FAIL rnd_rdata_k%0d got %h/%h want %h", k, bus.arb_if__rdata, bus.arb_mb__rdata, e_rdata);
            end
         end
         @(posedge clk); model_commit();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = {$urandom};
         ref_mem[i] = mem_arr[i];
      end
      r_rdata = '0;
      model_reset();
      test_reset();
      test_solo_fetch();
      test_starvation();
      test_write_read();
      test_flush_kill();
      test_alternating();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the shared memory.
REQ-002 Parameter STARVE_MAX, default 4, consecutive contested cycles that mb may win before if is forced to win.
REQ-003 Ports, in order: clk in 1, single clock; all state on posedge clk.
REQ-004 rst_n in 1: asynchronous, active-low reset.
REQ-005 if_arb__req in 1: instruction-fetch read request.
REQ-006 if_arb__addr in ADDR_W: fetch word address.
REQ-007 arb_if__gnt out 1: fetch request accepted this cycle.
REQ-008 arb_if__rvalid out 1: fetch read data valid.
REQ-009 arb_if__rdata out 32: fetch read data.
REQ-010 mb_arb__req in 1: data-stage request.
REQ-011 mb_arb__we in 1: 1 = write, 0 = read.
REQ-012 mb_arb__be in 4: write byte enables.
REQ-013 mb_arb__addr in ADDR_W; mb_arb__wdata in 32.
REQ-014 arb_mb__gnt out 1; arb_mb__rvalid out 1; arb_mb__rdata out 32: data-stage grant and response.
REQ-015 pipe_flush in 1: fetch redirect; kills any in-flight fetch response.
REQ-016 mem__en out 1; mem__we out 4 (byte write strobes); mem__addr out ADDR_W; mem__wdata out 32: single-port memory command.
REQ-017 mem__rdata in 32: memory read data, valid exactly one cycle after a read command.

Function
REQ-018 Grant is combinational from requests and registered state; at most one of arb_if__gnt, arb_mb__gnt is high per cycle.
REQ-019 Only if requests: if granted. Only mb requests: mb granted. Neither: no grant, mem__en = 0.
REQ-020 Both request (contested): mb granted unless starve_cnt == STARVE_MAX, in which case if is granted.
REQ-021 starve_cnt increments on each contested cycle won by mb, saturating at STARVE_MAX.
REQ-022 starve_cnt clears to 0 on any cycle if is granted; it holds on cycles with no contest.
REQ-023 Granted requester's address, write data and strobes drive mem__*; mem__we = mb_arb__be when mb is granted with mb_arb__we = 1, else 4'b0000.
REQ-024 A granted read sets registered rd_owner (NONE/IF/MB) for the next cycle; writes and idle cycles set NONE.
REQ-025 arb_if__rvalid = (rd_owner == IF) and no kill; arb_mb__rvalid = (rd_owner == MB); read latency is exactly one cycle after grant.
REQ-026 pipe_flush high while rd_owner == IF, or in the grant cycle of that read, suppresses arb_if__rvalid for that read.
REQ-027 arb_if__rdata and arb_mb__rdata both carry mem__rdata; each is meaningful only when its rvalid is high.
REQ-028 Grant is independent of pipe_flush in the same cycle: a fetch granted while pipe_flush is high still issues to memory, and its response is killed.
REQ-029 Write-only traffic produces no rvalid on either port.
REQ-030 Back-to-back grants to alternating requesters every cycle are permitted; no bubble is inserted.

Reset
REQ-031 rst_n low asynchronously forces rd_owner = NONE, starve_cnt = 0 and the kill flag = 0.
REQ-032 During reset, all gnt and rvalid outputs = 0 and mem__en = 0, regardless of requests.
REQ-033 A read in flight when reset asserts is dropped; no rvalid appears after release for a pre-reset read.

Structure
REQ-034 The shared package holds the rd_owner enum (OWN_NONE, OWN_IF, OWN_MB) and the default STARVE_MAX constant.
REQ-035 No sub-module; the single-port memory is instantiated outside this block.

Verification
REQ-036 Solo fetch: if_arb__req = 1, addr 0x10 with mem[0x10] = 0xDEADBEEF -> gnt in cycle N; arb_if__rvalid with 0xDEADBEEF in cycle N+1.
REQ-037 Starvation: both request continuously -> mb granted 4 cycles, if granted the 5th, starve_cnt = 0 afterwards, pattern repeats.
REQ-038 Write then read: mb write addr 0x20, be 4'b0011, wdata 0x1234ABCD onto 0x00000000, then mb read 0x20 -> arb_mb__rvalid with 0x0000ABCD; no rvalid in the write cycle+1.
REQ-039 Flush kill: fetch granted in cycle N, pipe_flush = 1 in cycle N+1 -> arb_if__rvalid stays 0 in cycle N+1.
REQ-040 Async reset: rst_n low mid-cycle with a read in flight -> gnt, rvalid and mem__en go 0 immediately; after release, no stale rvalid.
REQ-041 Alternating traffic: if and mb requesting on alternate cycles -> every request granted in its own cycle, responses routed to the correct port.
